// File: rtl/run_expander_if.sv
// Write-side and output-stream signals of run_expander.
// RUN_EXPANDER_LAST_EN adds the out_last sideband to the stream.
interface run_expander_if #(
  parameter int unsigned word_size = 32,
  parameter int unsigned rep_size  = 8
);
  logic                 wr_en;
  logic [word_size-1:0] wr_val;
  logic [rep_size-1:0]  wr_rep;
  logic                 full;
  logic                 out_valid;
  logic                 out_ready;
  logic [word_size-1:0] out_data;
`ifdef RUN_EXPANDER_LAST_EN
  logic                 out_last;
`endif

  modport master (
    output wr_en, wr_val, wr_rep, out_ready,
`ifdef RUN_EXPANDER_LAST_EN
    input  out_last,
`endif
    input  full, out_valid, out_data
  );

  modport slave (
    input  wr_en, wr_val, wr_rep, out_ready,
`ifdef RUN_EXPANDER_LAST_EN
    output out_last,
`endif
    output full, out_valid, out_data
  );
endinterface

// File: rtl/run_expander.sv
// Expands a buffer of (value, repeat) pairs into a valid/ready word stream.
// Define RUN_EXPANDER_LAST_EN to drive out_last on the final word of a run.
module run_expander #(
  parameter int unsigned buff_size = 128,
  parameter int unsigned word_size = 32,
  parameter int unsigned rep_size  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Ld,
  input  logic        En,
  output logic        busy,
  output logic        done,
  output logic [31:0] count,
  run_expander_if.slave bus
);

  localparam int unsigned addr_w = (buff_size > 1) ? $clog2(buff_size) : 1;
  localparam int unsigned ptr_w  = $clog2(buff_size + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StEmit} state_e;

  state_e               state_q;
  logic [ptr_w-1:0]     wr_ptr_q;
  logic [ptr_w-1:0]     rd_ptr_q;
  logic [rep_size-1:0]  rep_left_q;
  logic                 out_valid_q;
  logic [word_size-1:0] out_data_q;
  logic                 done_q;
  logic [31:0]          count_q;

  logic [word_size-1:0] val_mem [buff_size];
  logic [rep_size-1:0]  rep_mem [buff_size];

  logic                 full;
  logic                 wr_fire;
  logic [word_size-1:0] cur_val;
  logic [rep_size-1:0]  cur_rep;

  assign full    = (wr_ptr_q == ptr_w'(buff_size));
  assign wr_fire = (state_q == StIdle) && !Ld && !En && bus.wr_en && !full;
  assign cur_val = val_mem[rd_ptr_q[addr_w-1:0]];
  assign cur_rep = rep_mem[rd_ptr_q[addr_w-1:0]];

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign count         = count_q;
  assign bus.full      = full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef RUN_EXPANDER_LAST_EN
  logic [buff_size-1:0] nz_q;
  logic                 nz_after;
  logic                 out_last_q;

  // Any entry strictly after rd_ptr and below wr_ptr with a nonzero repeat.
  always_comb begin
    nz_after = 1'b0;
    for (int unsigned i = 0; i < buff_size; i++) begin
      if (nz_q[i] && (ptr_w'(i) > rd_ptr_q) && (ptr_w'(i) < wr_ptr_q)) begin
        nz_after = 1'b1;
      end
    end
  end

  assign bus.out_last = out_last_q;
`endif

  // Buffer storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      val_mem[wr_ptr_q[addr_w-1:0]] <= bus.wr_val;
      rep_mem[wr_ptr_q[addr_w-1:0]] <= bus.wr_rep;
`ifdef RUN_EXPANDER_LAST_EN
      nz_q[wr_ptr_q[addr_w-1:0]]    <= (bus.wr_rep != '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rep_left_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      count_q     <= '0;
`ifdef RUN_EXPANDER_LAST_EN
      out_last_q  <= 1'b0;
`endif
    end else if (Ld) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rep_left_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef RUN_EXPANDER_LAST_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (En) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            state_q  <= StFetch;
          end else if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + ptr_w'(1);
          end
        end
        StFetch: begin
          if (rd_ptr_q == wr_ptr_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (cur_rep == '0) begin
            rd_ptr_q <= rd_ptr_q + ptr_w'(1);
          end else begin
            rep_left_q  <= cur_rep;
            out_data_q  <= cur_val;
            out_valid_q <= 1'b1;
            state_q     <= StEmit;
`ifdef RUN_EXPANDER_LAST_EN
            out_last_q  <= (cur_rep == rep_size'(1)) && !nz_after;
`endif
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            count_q    <= count_q + 32'd1;
            rep_left_q <= rep_left_q - rep_size'(1);
            if (rep_left_q == rep_size'(1)) begin
              out_valid_q <= 1'b0;
              rd_ptr_q    <= rd_ptr_q + ptr_w'(1);
              state_q     <= StFetch;
            end
`ifdef RUN_EXPANDER_LAST_EN
            if (rep_left_q == rep_size'(1)) begin
              out_last_q <= 1'b0;
            end else if (rep_left_q == rep_size'(2)) begin
              out_last_q <= !nz_after;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_run_expander.sv
// Scoreboard bench for run_expander: expected words are queued when a run is
// started and popped as the stream is accepted.
module tb_run_expander;

  localparam int unsigned BUFF = 128;
  localparam int unsigned WORD = 32;
  localparam int unsigned REP  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        Ld;
  logic        En;
  logic        busy;
  logic        done;
  logic [31:0] count;

  run_expander_if #(.word_size(WORD), .rep_size(REP)) bus ();

  run_expander #(.buff_size(BUFF), .word_size(WORD), .rep_size(REP)) dut (
    .clk   (clk),
    .rst   (rst),
    .Ld    (Ld),
    .En    (En),
    .busy  (busy),
    .done  (done),
    .count (count),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [WORD-1:0] sb [$];
  logic [WORD-1:0] mval [BUFF];
  logic [REP-1:0]  mrep [BUFF];
  int              mptr = 0;

  int              ready_mode = 0;
  int              pat_i = 0;
  int              done_cnt = 0;
  int              valid_seen = 0;
  logic            stall_prev = 1'b0;
  logic [WORD-1:0] data_prev;
  logic [WORD-1:0] exp_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle; a word is taken at the next rising edge.
  always @(negedge clk) begin
    if (rst && !Ld) begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.out_data, data_prev);
      end
      if (bus.out_valid) valid_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          exp_w = sb.pop_front();
`ifdef RUN_EXPANDER_LAST_EN
          check("out_last", 32'(bus.out_last), 32'(sb.size() == 0));
`endif
          check("data", bus.out_data, exp_w);
        end
      end
      if (done) done_cnt++;
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Sink: always ready, 1,0,0 repeating, or random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = (pat_i % 3 == 0); pat_i++; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [WORD-1:0] v, input logic [REP-1:0] r);
    bus.wr_en  = 1'b1;
    bus.wr_val = v;
    bus.wr_rep = r;
    step();
    bus.wr_en  = 1'b0;
    if (mptr < BUFF) begin
      mval[mptr] = v;
      mrep[mptr] = r;
      mptr++;
    end
  endtask

  task automatic clear();
    Ld = 1'b1;
    step();
    Ld = 1'b0;
    mptr = 0;
    sb.delete();
  endtask

  task automatic push_expected(output int words, output int steps, output int first);
    words = 0;
    steps = 1;
    first = -1;
    for (int i = 0; i < mptr; i++) begin
      if (first < 0 && mrep[i] != '0) first = 1 + i;
      steps += 1 + int'(mrep[i]);
      for (int j = 0; j < int'(mrep[i]); j++) begin
        sb.push_back(mval[i]);
        words++;
      end
    end
  endtask

  task automatic run();
    int words, steps, first, n, seen;
    push_expected(words, steps, first);
    n    = 0;
    seen = -1;
    En = 1'b1;
    step();
    En = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
    while (!done && n < 4000) begin
      step();
      n++;
      if (bus.out_valid && seen < 0) seen = n;
    end
    check("done_seen", 32'(done), 32'd1);
    if (ready_mode == 0) check("done_lat", n, steps);
    check("first_valid", seen, first);
    check("count", count, words);
    check("sb_drained", sb.size(), 32'd0);
    step();
    check("done_pulse", 32'(done), 32'd0);
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int words, steps, first, v0, d0;
    rst = 1'b0;
    Ld = 1'b0;
    En = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_val = '0;
    bus.wr_rep = '0;
    #3;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Basic expansion with a skipped zero-repeat entry, then a replay with stalls.
    write(32'd5, 8'd3);
    write(32'd7, 8'd0);
    write(32'd9, 8'd2);
    ready_mode = 0;
    run();
    ready_mode = 1;
    run();

    // Empty buffer.
    ready_mode = 0;
    clear();
    v0 = valid_seen;
    run();
    check("empty_no_valid", valid_seen - v0, 32'd0);

    // Fill to capacity; the extra write is dropped.
    clear();
    for (int i = 0; i < 129; i++) begin
      write(32'(i), 8'd1);
      if (i == 126) check("not_full_127", 32'(bus.full), 32'd0);
      if (i == 127) check("full_128", 32'(bus.full), 32'd1);
    end
    check("full_129", 32'(bus.full), 32'd1);
    run();

    // Abort with Ld after two transfers.
    clear();
    write(32'd5, 8'd3);
    write(32'd7, 8'd0);
    write(32'd9, 8'd2);
    push_expected(words, steps, first);
    En = 1'b1;
    step();
    En = 1'b0;
    step();
    step();
    step();
    check("ld_pre_count", count, 32'd2);
    check("ld_pre_valid", 32'(bus.out_valid), 32'd1);
    d0 = done_cnt;
    Ld = 1'b1;
    step();
    Ld = 1'b0;
    check("ld_valid", 32'(bus.out_valid), 32'd0);
    check("ld_busy", 32'(busy), 32'd0);
    check("ld_full", 32'(bus.full), 32'd0);
    check("ld_count", count, 32'd2);
    step();
    step();
    check("ld_no_done", done_cnt - d0, 32'd0);
    check("ld_count_held", count, 32'd2);
    mptr = 0;
    sb.delete();

    // Asynchronous reset mid-run.
    write(32'd1, 8'd4);
    write(32'd2, 8'd4);
    push_expected(words, steps, first);
    En = 1'b1;
    step();
    En = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_count", count, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_full", 32'(bus.full), 32'd0);
    step();
    rst = 1'b1;
    mptr = 0;
    sb.delete();
    step();
    run();

    // Random entries under a random sink, then the same buffer at full rate.
    for (int k = 0; k < 8; k++) write($urandom, 8'($urandom_range(0, 3)));
    ready_mode = 2;
    run();
    ready_mode = 0;
    run();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
